// File: rtl/reaction_timer_bcd.sv
// Reaction-time tester core. It waits a fixed-plus-pseudo-random delay, raises a
// prompt, then counts ticks in a BCD counter until the player presses. It also
// detects early presses and counter saturation, and keeps the best result.
module reaction_timer_bcd #(
    parameter int          DIGITS    = 4,
    parameter int          TICK_DIV  = 100000,
    parameter int          MIN_WAIT  = 1000,
    parameter logic [7:0]  RAND_MASK = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  press,
    output logic [4*DIGITS-1:0]   digits,
    output logic [4*DIGITS-1:0]   best,
    output logic                  best_valid,
    output logic                  prompt,
    output logic                  done,
    output logic                  foul,
    output logic                  overflow,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_FOUL  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam int            TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int            DW        = $clog2(MIN_WAIT + 256 + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t                cur;
    state_t                nxt;
    logic [TW-1:0]         tick_cnt;
    logic [DW-1:0]         dly;
    logic [7:0]            lfsr;
    logic                  active;
    logic                  tick;
    logic                  arm;
    logic                  done_entry;
    logic                  carry;
    logic                  all_nine;
    logic [4*DIGITS-1:0]   digits_inc;

    // The divider only runs while waiting or counting, so the tick is gated too.
    assign active = (cur == S_ARMED) || (cur == S_RUN);
    assign tick   = active && (tick_cnt == TICK_LAST);
    // A start is honoured only from the idle-like states.
    assign arm    = start && ((cur == S_IDLE) || (cur == S_DONE) ||
                              (cur == S_FOUL) || (cur == S_OVER));
    assign state  = cur;

    // BCD increment with full carry ripple; a carry out of the top digit means all nines.
    always_comb begin
        digits_inc = digits;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        all_nine = carry;
    end

    // Next-state logic; a press always wins over a same-cycle tick.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:  if (start) nxt = S_ARMED;
            S_ARMED: begin
                if (press)                          nxt = S_FOUL;
                else if (tick && dly == DW'(1))     nxt = S_RUN;
            end
            S_RUN: begin
                if (press)                          nxt = S_DONE;
                else if (tick && all_nine)          nxt = S_OVER;
            end
            S_DONE, S_FOUL, S_OVER: if (start) nxt = S_ARMED;
            default: nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Pseudo-random source, free running in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= 8'h01;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Tick divider restarts whenever the machine enters or leaves a counting state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (active && ((nxt == S_ARMED) || (nxt == S_RUN))) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end else begin
            tick_cnt <= '0;
        end
    end

    // Pre-prompt delay: loaded on arming, counted down one step per tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly <= '0;
        end else if (arm) begin
            dly <= DW'(MIN_WAIT) + DW'(lfsr & RAND_MASK);
        end else if (cur == S_ARMED && tick && !press) begin
            dly <= dly - DW'(1);
        end
    end

    // Result counter: cleared on arming, advanced by ticks in RUN, frozen otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits <= '0;
        end else if (arm) begin
            digits <= '0;
        end else if (cur == S_RUN && tick && !press && !all_nine) begin
            digits <= digits_inc;
        end
    end

    // Best result is judged one cycle after entering DONE, using the frozen count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_entry <= 1'b0;
            best       <= '0;
            best_valid <= 1'b0;
        end else begin
            done_entry <= (cur == S_RUN) && press;
            if (done_entry && (!best_valid || digits < best)) begin
                best       <= digits;
                best_valid <= 1'b1;
            end
        end
    end

    // Status flags are registered decodes of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prompt   <= 1'b0;
            done     <= 1'b0;
            foul     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            prompt   <= (nxt == S_RUN);
            done     <= (nxt == S_DONE);
            foul     <= (nxt == S_FOUL);
            overflow <= (nxt == S_OVER);
        end
    end

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Self-checking bench for reaction_timer_bcd: a timing-based behavioural model
// is compared against the DUT every cycle, plus hand-computed directed checks.
module tb_reaction_timer_bcd;

    localparam int         DIG  = 2;
    localparam int         TD   = 4;
    localparam int         MW   = 2;
    localparam logic [7:0] MASK = 8'h00;
    localparam int         MAXV = 10 ** DIG;

    logic             clk;
    logic             reset;
    logic             start;
    logic             press;
    logic [4*DIG-1:0] digits;
    logic [4*DIG-1:0] best;
    logic             best_valid;
    logic             prompt;
    logic             done;
    logic             foul;
    logic             overflow;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: a mode number plus the cycle landmarks that define all timing.
    int         m_state  = 0;
    int         m_run_at = 0;
    int         m_r      = 0;
    int         m_result = 0;
    int         m_best   = 0;
    bit         m_bv     = 0;
    bit         m_pend   = 0;
    logic [7:0] m_lfsr   = 8'h01;

    reaction_timer_bcd #(
        .DIGITS(DIG), .TICK_DIV(TD), .MIN_WAIT(MW), .RAND_MASK(MASK)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .press(press),
        .digits(digits), .best(best), .best_valid(best_valid),
        .prompt(prompt), .done(done), .foul(foul), .overflow(overflow),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index: during cycle c, cyc == c.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DIG-1:0] int2bcd(input int v);
        logic [4*DIG-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int modelCount();
        case (m_state)
            2:       return (cyc - m_r) / TD;
            3:       return m_result;
            5:       return MAXV - 1;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Behavioural model: each edge maps the inputs of cycle c onto cycle c+1.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_run_at = 0; m_r = 0; m_result = 0;
            m_best = 0; m_bv = 0; m_pend = 0; m_lfsr = 8'h01;
        end else begin
            if (m_pend) begin
                if (!m_bv || m_result < m_best) begin
                    m_best = m_result;
                    m_bv   = 1;
                end
                m_pend = 0;
            end
            case (m_state)
                1: begin
                    if (press) m_state = 4;
                    else if (cyc + 1 == m_run_at) begin
                        m_state = 2;
                        m_r     = cyc + 1;
                    end
                end
                2: begin
                    if (press) begin
                        m_result = (cyc - m_r) / TD;
                        m_state  = 3;
                        m_pend   = 1;
                    end else if (cyc + 1 == m_r + MAXV * TD) begin
                        m_state = 5;
                    end
                end
                default: begin
                    if (start) begin
                        m_state  = 1;
                        m_run_at = cyc + 1 + (MW + int'(m_lfsr & MASK)) * TD;
                    end
                end
            endcase
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        checkOutput("state", 32'(state), 32'(m_state));
        checkOutput("digits", 32'(digits), 32'(int2bcd(modelCount())));
        checkOutput("best", 32'({best_valid, best}), 32'({m_bv, int2bcd(m_best)}));
        checkOutput("flags", 32'({prompt, done, foul, overflow}),
                    32'({m_state == 2, m_state == 3, m_state == 4, m_state == 5}));
    end

    task automatic waitCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one-cycle pulses in the current cycle and returns in the next one.
    task automatic applyStimulus(input logic s, input logic p);
        start = s;
        press = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        press = 1'b0;
    endtask

    task automatic normalRun();
        int t;
        t = cyc;
        applyStimulus(1'b1, 1'b0);
        checkOutput("lit_armed_state", 32'(state), 32'd1);
        checkOutput("lit_armed_digits", 32'(digits), 32'h00);
        waitCycle(t + 8);
        checkOutput("lit_still_armed", 32'(state), 32'd1);
        waitCycle(t + 9);
        checkOutput("lit_run_state", 32'(state), 32'd2);
        checkOutput("lit_prompt", 32'(prompt), 32'd1);
        waitCycle(t + 157);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lit_done_state", 32'(state), 32'd3);
        checkOutput("lit_done_flag", 32'(done), 32'd1);
        checkOutput("lit_result_37", 32'(digits), 32'h37);
        @(posedge clk);
        #1;
        checkOutput("lit_best_37", 32'({best_valid, best}), 32'h137);
    endtask

    task automatic playRun(input int n, input bit collide, input bit noise);
        int t;
        int r;
        t = cyc;
        applyStimulus(1'b1, 1'b0);
        r = t + 1 + MW * TD;
        if (noise) begin
            waitCycle(t + 4);
            applyStimulus(1'b1, 1'b0);
            waitCycle(r + 2);
            applyStimulus(1'b1, 1'b0);
        end
        waitCycle(r + n * TD - (collide ? 1 : 0));
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
    endtask

    initial begin
        int a;
        int r;
        start = 1'b0;
        press = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lit_reset_state", 32'(state), 32'd0);
        checkOutput("lit_reset_digits", 32'(digits), 32'h00);
        checkOutput("lit_reset_best", 32'({best_valid, best}), 32'h000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("lit_idle_press_ignored", 32'(state), 32'd0);

        $display("[TB] normal run");
        normalRun();

        $display("[TB] best tracking");
        playRun(25, 1'b0, 1'b1);
        checkOutput("lit_best_25", 32'({best_valid, best}), 32'h125);
        playRun(41, 1'b0, 1'b0);
        checkOutput("lit_best_after_41", 32'({best_valid, best}), 32'h125);
        playRun(25, 1'b0, 1'b1);
        checkOutput("lit_best_repeat_25", 32'({best_valid, best}), 32'h125);

        $display("[TB] tick/press collision");
        playRun(13, 1'b1, 1'b0);
        checkOutput("lit_collision_digits", 32'(digits), 32'h12);
        checkOutput("lit_best_12", 32'({best_valid, best}), 32'h112);

        $display("[TB] foul and overflow");
        a = cyc;
        applyStimulus(1'b1, 1'b0);
        waitCycle(a + 5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("lit_foul_state", 32'(state), 32'd4);
        checkOutput("lit_foul_flag", 32'(foul), 32'd1);
        checkOutput("lit_foul_digits", 32'(digits), 32'h00);
        checkOutput("lit_foul_best", 32'({best_valid, best}), 32'h112);
        a = cyc;
        applyStimulus(1'b1, 1'b0);
        checkOutput("lit_rearm", 32'(state), 32'd1);
        r = a + 1 + MW * TD;
        waitCycle(r + 396);
        checkOutput("lit_digits_99", 32'(digits), 32'h99);
        checkOutput("lit_still_run", 32'(state), 32'd2);
        waitCycle(r + 400);
        checkOutput("lit_over_state", 32'(state), 32'd5);
        checkOutput("lit_over_flag", 32'(overflow), 32'd1);
        checkOutput("lit_over_digits", 32'(digits), 32'h99);
        checkOutput("lit_over_best", 32'({best_valid, best}), 32'h112);

        $display("[TB] reset mid-run");
        a = cyc;
        applyStimulus(1'b1, 1'b0);
        r = a + 1 + MW * TD;
        waitCycle(r + 28);
        checkOutput("lit_digits_07", 32'(digits), 32'h07);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("lit_async_state", 32'(state), 32'd0);
        checkOutput("lit_async_digits", 32'(digits), 32'h00);
        checkOutput("lit_async_best", 32'({best_valid, best}), 32'h000);
        checkOutput("lit_async_flags", 32'({prompt, done, foul, overflow}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        normalRun();

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 29) == 0);
            press = ($urandom_range(0, 39) == 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        press = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
